// File: rtl/lane_pattern_bank.sv
// rtl/lane_pattern_bank.sv - packed multi-lane pattern bank with per-lane/broadcast writes, fill sweep and registered read
// Optional parity storage and checking enabled by defining PATTERN_BANK_PARITY_EN.
module lane_pattern_bank #(
  parameter int LANES = 3,
  parameter int LANE_W = 64,
  parameter int DEPTH = 4,
  parameter logic [LANE_W-1:0] RESET_PATTERN = '0,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int EW = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [LW-1:0]     wr_lane,
  input  logic              wr_all,
  input  logic [LANE_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              fill_start,
  input  logic [LANE_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [EW-1:0]     rd_data,
  output logic              rd_valid
`ifdef PATTERN_BANK_PARITY_EN
  ,
  input  logic              wr_par_flip,
  output logic              rd_par_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t            state;
  logic [AW-1:0]     idx;
  logic [LANE_W-1:0] fill_val;
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     wr_entry;
  logic              wr_ok;
  logic              rd_ok;

`ifdef PATTERN_BANK_PARITY_EN
  logic [DEPTH-1:0]  par;
`endif

  // Merge the addressed lane(s) into the current entry so per-lane writes keep the other lanes.
  always_comb begin
    wr_entry = mem[wr_addr];
    for (int l = 0; l < LANES; l++) begin
      if (wr_all || (LW'(l) == wr_lane)) begin
        wr_entry[(LANES-l)*LANE_W-1 -: LANE_W] = wr_data;
      end
    end
    wr_ok = wr_en && (state != S_FILL) && (32'(wr_addr) < DEPTH) &&
            (wr_all || (32'(wr_lane) < LANES));
    rd_ok = 32'(rd_addr) < DEPTH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        mem[d] <= {LANES{RESET_PATTERN}};
      end
      state    <= S_IDLE;
      idx      <= '0;
      fill_val <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef PATTERN_BANK_PARITY_EN
      par        <= {DEPTH{^{LANES{RESET_PATTERN}}}};
      rd_par_err <= 1'b0;
`endif
    end else begin
      wr_err <= wr_en && !wr_ok;
      done   <= 1'b0;

      if (wr_ok) begin
        mem[wr_addr] <= wr_entry;
`ifdef PATTERN_BANK_PARITY_EN
        par[wr_addr] <= (^wr_entry) ^ wr_par_flip;
`endif
      end

      // A same-cycle write in IDLE lands first; the sweep starts on the following edge.
      case (state)
        S_IDLE: begin
          if (fill_start) begin
            fill_val <= fill_value;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          mem[idx] <= {LANES{fill_val}};
`ifdef PATTERN_BANK_PARITY_EN
          par[idx] <= ^{LANES{fill_val}};
`endif
          idx <= idx + 1'b1;
          if (idx == AW'(DEPTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Reads sample the array before this edge's write, giving read-first behaviour.
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_ok ? mem[rd_addr] : '0;
`ifdef PATTERN_BANK_PARITY_EN
        rd_par_err <= rd_ok && ((^mem[rd_addr]) != par[rd_addr]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_lane_pattern_bank.sv
// tb/tb_lane_pattern_bank.sv - scoreboard bench for lane_pattern_bank
module tb_lane_pattern_bank;

  localparam int LANES = 3;
  localparam int LANE_W = 64;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int LW = 2;
  localparam int EW = LANES * LANE_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [LW-1:0]     wr_lane;
  logic              wr_all;
  logic [LANE_W-1:0] wr_data;
  logic              wr_err;
  logic              fill_start;
  logic [LANE_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     rd_data;
  logic              rd_valid;
`ifdef PATTERN_BANK_PARITY_EN
  logic              wr_par_flip;
  logic              rd_par_err;
`endif

  lane_pattern_bank #(
    .LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .RESET_PATTERN('0)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane(wr_lane), .wr_all(wr_all),
    .wr_data(wr_data), .wr_err(wr_err),
    .fill_start(fill_start), .fill_value(fill_value), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
`ifdef PATTERN_BANK_PARITY_EN
    , .wr_par_flip(wr_par_flip), .rd_par_err(rd_par_err)
`endif
  );

  always #5 clk = ~clk;

  logic [EW-1:0] model [DEPTH];
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] exp_v;
  int vectors = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_lane(input int a, input int l, input logic [LANE_W-1:0] d);
    model[a][(LANES-l)*LANE_W-1 -: LANE_W] = d;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input logic all, input logic [LANE_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_lane = l; wr_all = all; wr_data = d;
    tick();
    wr_en = 1'b0; wr_all = 1'b0;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back(model[a]);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int d = 0; d < DEPTH; d++) model[d] = '0;
    vectors++;
    if ({busy, done, wr_err, rd_valid} !== 4'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b wr_err=%b rd_valid=%b rd_data=%h expected all zero",
               busy, done, wr_err, rd_valid, rd_data);
    end
    drive_read(2);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v || rd_data !== 192'h0) begin
      errors++;
      $display("FAIL reset_read valid=%b data=%h expected valid=1 data=%h", rd_valid, rd_data, exp_v);
    end
  endtask

  task automatic test_lane_write();
    logic [LANE_W-1:0] vals [3] = '{64'h9, 64'h12, 64'h21};
    for (int l = 0; l < LANES; l++) begin
      drive_write(1, LW'(l), 1'b0, vals[l]);
      model_lane(1, l, vals[l]);
      vectors++;
      if (wr_err !== 1'b0) begin
        errors++;
        $display("FAIL lane_write_err lane=%0d wr_err=%b expected 0", l, wr_err);
      end
    end
    drive_read(1);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v || rd_data !== {64'h9, 64'h12, 64'h21}) begin
      errors++;
      $display("FAIL lane_write_read valid=%b data=%h expected %h", rd_valid, rd_data, exp_v);
    end
  endtask

  task automatic test_wr_all();
    drive_write(3, 2'd3, 1'b1, 64'h1);
    for (int l = 0; l < LANES; l++) model_lane(3, l, 64'h1);
    vectors++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_all_err wr_err=%b expected 0", wr_err);
    end
    drive_read(3);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rd_data !== exp_v || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL wr_all_read valid=%b data=%h expected %h", rd_valid, rd_data, exp_v);
    end
  endtask

  task automatic test_fill();
    fill_start = 1'b1; fill_value = 64'hAA;
    tick();
    fill_start = 1'b0; fill_value = 64'h0;
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if (busy !== (c <= 4) || done !== (c == 5)) begin
        errors++;
        $display("FAIL fill_timing cycle=%0d busy=%b done=%b expected busy=%b done=%b",
                 c, busy, done, c <= 4, c == 5);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_done_pulse busy=%b done=%b expected 0 0", busy, done);
    end
    for (int d = 0; d < DEPTH; d++) model[d] = {3{64'hAA}};
    for (int d = 0; d < DEPTH; d++) begin
      drive_read(AW'(d));
      exp_v = exp_q.pop_front();
      vectors++;
      if (rd_data !== exp_v || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL fill_read addr=%0d data=%h expected %h", d, rd_data, exp_v);
      end
    end
  endtask

  task automatic test_wr_err();
    fill_start = 1'b1; fill_value = 64'h55;
    tick();
    fill_start = 1'b0;
    tick(); tick(); tick();
    drive_write(0, 0, 1'b0, 64'h77);
    vectors++;
    if (wr_err !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL busy_write wr_err=%b done=%b expected 1 1", wr_err, done);
    end
    tick();
    vectors++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_err_pulse wr_err=%b expected 0", wr_err);
    end
    for (int d = 0; d < DEPTH; d++) model[d] = {3{64'h55}};
    drive_read(0);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rd_data !== exp_v) begin
      errors++;
      $display("FAIL busy_write_data data=%h expected %h", rd_data, exp_v);
    end
    drive_write(2, 2'd3, 1'b0, 64'hDEAD);
    vectors++;
    if (wr_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_lane_err wr_err=%b expected 1", wr_err);
    end
    drive_read(2);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rd_data !== exp_v) begin
      errors++;
      $display("FAIL bad_lane_data data=%h expected %h", rd_data, exp_v);
    end
  endtask

  task automatic test_read_first();
    rd_en = 1'b1; rd_addr = 1;
    exp_q.push_back(model[1]);
    wr_en = 1'b1; wr_addr = 1; wr_lane = 2; wr_all = 1'b0; wr_data = 64'h123;
    tick();
    wr_en = 1'b0;
    model_lane(1, 2, 64'h123);
    exp_q.push_back(model[1]);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rd_data !== exp_v || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_first data=%h expected old %h", rd_data, exp_v);
    end
    tick();
    rd_en = 1'b0;
    exp_v = exp_q.pop_front();
    vectors++;
    if (rd_data !== exp_v || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_after_write data=%h expected %h", rd_data, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    drive_write(2, 0, 1'b0, 64'hBEEF);
    model_lane(2, 0, 64'hBEEF);
    rd_en = 1'b1;
    for (int d = 0; d < DEPTH; d++) begin
      rd_addr = AW'(d);
      exp_q.push_back(model[d]);
      tick();
      exp_v = exp_q.pop_front();
      vectors++;
      if (rd_data !== exp_v || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_read addr=%0d data=%h expected %h", d, rd_data, exp_v);
      end
    end
    rd_en = 1'b0;
    rd_addr = 0;
    tick();
    vectors++;
    if (rd_valid !== 1'b0 || rd_data !== model[3]) begin
      errors++;
      $display("FAIL read_hold valid=%b data=%h expected valid=0 data=%h", rd_valid, rd_data, model[3]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    fill_start = 1'b1; fill_value = 64'hCC;
    tick();
    fill_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < DEPTH; d++) model[d] = '0;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort_sweep cycle=%0d busy=%b done=%b expected 0 0", c, busy, done);
      end
      tick();
    end
    for (int d = 0; d < DEPTH; d++) begin
      drive_read(AW'(d));
      exp_v = exp_q.pop_front();
      vectors++;
      if (rd_data !== exp_v || rd_data !== 192'h0) begin
        errors++;
        $display("FAIL abort_read addr=%0d data=%h expected %h", d, rd_data, exp_v);
      end
    end
  endtask

`ifdef PATTERN_BANK_PARITY_EN
  task automatic test_parity();
    wr_par_flip = 1'b1;
    drive_write(0, 0, 1'b0, 64'h5);
    wr_par_flip = 1'b0;
    model_lane(0, 0, 64'h5);
    drive_read(0);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rd_par_err !== 1'b1 || rd_data !== exp_v) begin
      errors++;
      $display("FAIL parity_flip par_err=%b data=%h expected 1 %h", rd_par_err, rd_data, exp_v);
    end
    drive_write(0, 1, 1'b0, 64'h3);
    model_lane(0, 1, 64'h3);
    drive_read(0);
    exp_v = exp_q.pop_front();
    vectors++;
    if (rd_par_err !== 1'b0 || rd_data !== exp_v) begin
      errors++;
      $display("FAIL parity_clean par_err=%b data=%h expected 0 %h", rd_par_err, rd_data, exp_v);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_lane = '0; wr_all = 1'b0; wr_data = '0;
    fill_start = 1'b0; fill_value = '0; rd_en = 1'b0; rd_addr = '0;
`ifdef PATTERN_BANK_PARITY_EN
    wr_par_flip = 1'b0;
`endif
    test_reset();
    test_lane_write();
    test_wr_all();
    test_fill();
    test_wr_err();
    test_read_first();
    test_back_to_back();
    test_reset_mid_sweep();
`ifdef PATTERN_BANK_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
